// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the shared datapath.
// The master side is the controller: it reads instruction fields and status, and drives selects and enables.
interface multicycle_controller_if;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic       CondEx;
   logic       MemReady;

   logic       IRWrite;
   logic       MemWrite;
   logic       RegWrite;
   logic       PCWrite;
   logic       FlagWrite;
   logic       AdrSrc;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic [1:0] ALUControl;
   logic [1:0] ImmSrc;
   logic [1:0] RegSrc;
   logic       Undef;

   modport master (
      input  Op, Funct, Rd, CondEx, MemReady,
      output IRWrite, MemWrite, RegWrite, PCWrite, FlagWrite,
      output AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc, Undef
   );

   modport slave (
      output Op, Funct, Rd, CondEx, MemReady,
      input  IRWrite, MemWrite, RegWrite, PCWrite, FlagWrite,
      input  AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc, Undef
   );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle ARM-subset core: Moore state decode for the datapath selects,
// with architectural write enables gated by the condition check and forced off while reset is held.
module multicycle_controller (
   input  logic                           clk,
   input  logic                           reset,
   multicycle_controller_if.master        bus
);

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN
   } state_e;

   state_e state_q, state_d;

   logic nextPC, regW, memW, br, aluOp, undefRaw, pcs;

   always_ff @(posedge clk) begin
      if (!reset) state_q <= FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      nextPC        = 1'b0;
      regW          = 1'b0;
      memW          = 1'b0;
      br            = 1'b0;
      aluOp         = 1'b0;
      undefRaw      = 1'b0;
      bus.AdrSrc    = 1'b0;
      bus.ALUSrcA   = 1'b0;
      bus.ALUSrcB   = 2'b00;
      bus.ResultSrc = 2'b00;
      case (state_q)
         FETCH: begin
            bus.ALUSrcA   = 1'b1;
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
            nextPC        = bus.MemReady;
            if (bus.MemReady) state_d = DECODE;
         end
         DECODE: begin
            bus.ALUSrcA   = 1'b1;
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
            case (bus.Op)
               2'b00:   state_d = bus.Funct[5] ? EXECUTEI : EXECUTER;
               2'b01:   state_d = MEMADR;
               2'b10:   state_d = BRANCH;
               default: state_d = UNKNOWN;
            endcase
         end
         MEMADR: begin
            bus.ALUSrcB = 2'b01;
            state_d     = bus.Funct[0] ? MEMRD : MEMWR;
         end
         MEMRD: begin
            bus.AdrSrc = 1'b1;
            if (bus.MemReady) state_d = MEMWB;
         end
         MEMWB: begin
            bus.ResultSrc = 2'b01;
            regW          = 1'b1;
            state_d       = FETCH;
         end
         MEMWR: begin
            bus.AdrSrc = 1'b1;
            memW       = bus.MemReady;
            if (bus.MemReady) state_d = FETCH;
         end
         EXECUTER: begin
            aluOp   = 1'b1;
            state_d = ALUWB;
         end
         EXECUTEI: begin
            bus.ALUSrcB = 2'b01;
            aluOp       = 1'b1;
            state_d     = ALUWB;
         end
         ALUWB: begin
            regW    = 1'b1;
            aluOp   = 1'b1;
            state_d = FETCH;
         end
         BRANCH: begin
            bus.ALUSrcB   = 2'b01;
            bus.ResultSrc = 2'b10;
            br            = 1'b1;
            state_d       = FETCH;
         end
         UNKNOWN: begin
            undefRaw = 1'b1;
            state_d  = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   // Unrecognised data-processing commands quietly fall back to ADD rather than trapping.
   always_comb begin
      bus.ALUControl = 2'b00;
      if (aluOp) begin
         case (bus.Funct[4:1])
            4'b0100: bus.ALUControl = 2'b00;
            4'b0010: bus.ALUControl = 2'b01;
            4'b0000: bus.ALUControl = 2'b10;
            4'b1100: bus.ALUControl = 2'b11;
            default: bus.ALUControl = 2'b00;
         endcase
      end
   end

   // Writes to R15 redirect the PC instead of the register file; reset masks every commit.
   assign pcs           = (regW & (bus.Rd == 4'd15)) | br;
   assign bus.IRWrite   = reset & nextPC;
   assign bus.PCWrite   = reset & (nextPC | (pcs & bus.CondEx));
   assign bus.RegWrite  = reset & regW & bus.CondEx & (bus.Rd != 4'd15);
   assign bus.MemWrite  = reset & memW & bus.CondEx;
   assign bus.FlagWrite = reset & (state_q == ALUWB) & bus.Funct[0] & bus.CondEx;
   assign bus.Undef     = reset & undefRaw;
   assign bus.ImmSrc    = bus.Op;
   assign bus.RegSrc    = {bus.Op == 2'b01, bus.Op == 2'b10};

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: an instruction-level model (class + step within the instruction)
// predicts every output each cycle; directed instructions add literal expectations on top.
module tb_multicycle_controller;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   multicycle_controller_if bus();

   multicycle_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic       irw;
      logic       memw;
      logic       regw;
      logic       pcw;
      logic       flagw;
      logic       adrSrc;
      logic       srcA;
      logic [1:0] srcB;
      logic [1:0] resSrc;
      logic [1:0] aluCtl;
      logic [1:0] immSrc;
      logic [1:0] regSrc;
      logic       undef;
   } outs_t;

   localparam int C_DPR = 0;
   localparam int C_DPI = 1;
   localparam int C_LDR = 2;
   localparam int C_STR = 3;
   localparam int C_BR  = 4;
   localparam int C_UND = 5;

   int    total = 0;
   int    bad = 0;
   int    cycle = 0;
   int    mStep = 0;
   int    mClass = C_UND;
   bit    mValid = 1'b0;
   outs_t snap [1:8];

   function automatic int classify(input logic [1:0] op, input logic [5:0] f);
      case (op)
         2'b00:   return f[5] ? C_DPI : C_DPR;
         2'b01:   return f[0] ? C_LDR : C_STR;
         2'b10:   return C_BR;
         default: return C_UND;
      endcase
   endfunction

   // Step 0 is the fetch, 1 the decode; later steps depend on the instruction class.
   function automatic outs_t modelOut(input int cls, input int step, input logic rst,
                                      input logic [1:0] op, input logic [5:0] f,
                                      input logic [3:0] rd, input logic ce, input logic mr);
      outs_t o;
      logic  regW, memW, br, nextPc, aluOp, und, isDp;
      o = '0;
      regW = 0; memW = 0; br = 0; nextPc = 0; aluOp = 0; und = 0;
      isDp = (cls == C_DPR) || (cls == C_DPI);
      case (step)
         0: begin o.srcA = 1; o.srcB = 2; o.resSrc = 2; nextPc = mr; end
         1: begin o.srcA = 1; o.srcB = 2; o.resSrc = 2; end
         2: begin
            if (cls == C_DPR) aluOp = 1;
            else if (cls == C_DPI) begin o.srcB = 1; aluOp = 1; end
            else if (cls == C_LDR || cls == C_STR) o.srcB = 1;
            else if (cls == C_BR) begin o.srcB = 1; o.resSrc = 2; br = 1; end
            else und = 1;
         end
         3: begin
            if (isDp) begin regW = 1; aluOp = 1; end
            else if (cls == C_LDR) o.adrSrc = 1;
            else begin o.adrSrc = 1; memW = mr; end
         end
         default: begin o.resSrc = 1; regW = 1; end
      endcase
      if (aluOp) begin
         if (f[4:1] == 4'd2)       o.aluCtl = 2'd1;
         else if (f[4:1] == 4'd0)  o.aluCtl = 2'd2;
         else if (f[4:1] == 4'd12) o.aluCtl = 2'd3;
         else                      o.aluCtl = 2'd0;
      end
      o.irw    = rst & nextPc;
      o.pcw    = rst & (nextPc | (((regW & (rd == 4'd15)) | br) & ce));
      o.regw   = rst & regW & ce & (rd != 4'd15);
      o.memw   = rst & memW & ce;
      o.flagw  = rst & isDp & (step == 3) & f[0] & ce;
      o.undef  = rst & und;
      o.immSrc = op;
      o.regSrc = {op == 2'b01, op == 2'b10};
      return o;
   endfunction

   function automatic outs_t sampleDut();
      outs_t o;
      o.irw = bus.IRWrite;   o.memw = bus.MemWrite; o.regw = bus.RegWrite;
      o.pcw = bus.PCWrite;   o.flagw = bus.FlagWrite;
      o.adrSrc = bus.AdrSrc; o.srcA = bus.ALUSrcA;  o.srcB = bus.ALUSrcB;
      o.resSrc = bus.ResultSrc; o.aluCtl = bus.ALUControl;
      o.immSrc = bus.ImmSrc; o.regSrc = bus.RegSrc; o.undef = bus.Undef;
      return o;
   endfunction

   task automatic cmp(input string name, input logic [1:0] act, input logic [1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic checkOutput(input outs_t g, input outs_t e);
      cmp("IRWrite", 2'(g.irw), 2'(e.irw));
      cmp("MemWrite", 2'(g.memw), 2'(e.memw));
      cmp("RegWrite", 2'(g.regw), 2'(e.regw));
      cmp("PCWrite", 2'(g.pcw), 2'(e.pcw));
      cmp("FlagWrite", 2'(g.flagw), 2'(e.flagw));
      cmp("AdrSrc", 2'(g.adrSrc), 2'(e.adrSrc));
      cmp("ALUSrcA", 2'(g.srcA), 2'(e.srcA));
      cmp("ALUSrcB", g.srcB, e.srcB);
      cmp("ResultSrc", g.resSrc, e.resSrc);
      cmp("ALUControl", g.aluCtl, e.aluCtl);
      cmp("ImmSrc", g.immSrc, e.immSrc);
      cmp("RegSrc", g.regSrc, e.regSrc);
      cmp("Undef", 2'(g.undef), 2'(e.undef));
   endtask

   // One clock cycle: drive inputs, check at the falling edge, then advance the model over the rising edge.
   task automatic applyStimulus(input logic r, input logic [1:0] op, input logic [5:0] f,
                                input logic [3:0] rd, input logic ce, input logic mr,
                                output outs_t got);
      reset = r; bus.Op = op; bus.Funct = f; bus.Rd = rd; bus.CondEx = ce; bus.MemReady = mr;
      @(negedge clk);
      cycle++;
      got = sampleDut();
      if (mValid) checkOutput(got, modelOut(mClass, mStep, r, op, f, rd, ce, mr));
      if (!r) begin
         mStep = 0;
         mValid = 1'b1;
      end else begin
         case (mStep)
            0: if (mr) mStep = 1;
            1: begin mClass = classify(op, f); mStep = 2; end
            2: mStep = (mClass == C_BR || mClass == C_UND) ? 0 : 3;
            3: if (mClass == C_DPR || mClass == C_DPI) mStep = 0;
               else if (mr) mStep = (mClass == C_LDR) ? 4 : 0;
            default: mStep = 0;
         endcase
      end
      @(posedge clk);
      #1;
   endtask

   task automatic runInstr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                           input logic ce, input int n, input logic [7:0] mrPat);
      outs_t g;
      for (int i = 1; i <= n; i++) begin
         applyStimulus(1'b1, op, f, rd, ce, mrPat[i-1], g);
         snap[i] = g;
      end
   endtask

   initial begin
      outs_t g;
      logic [1:0] op;
      logic [5:0] f;
      logic [3:0] rd;
      logic [3:0] cmds [4];
      cmds[0] = 4'd4; cmds[1] = 4'd2; cmds[2] = 4'd0; cmds[3] = 4'd12;

      applyStimulus(1'b0, 2'b00, 6'd0, 4'd0, 1'b1, 1'b1, g);
      cmp("rst_irw", 2'(g.irw), 2'd0);
      cmp("rst_pcw", 2'(g.pcw), 2'd0);

      // STR up to its memory-write step, then reset held there with the memory ready.
      applyStimulus(1'b1, 2'b01, 6'b000000, 4'd4, 1'b1, 1'b1, g);
      applyStimulus(1'b1, 2'b01, 6'b000000, 4'd4, 1'b1, 1'b1, g);
      applyStimulus(1'b1, 2'b01, 6'b000000, 4'd4, 1'b1, 1'b1, g);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 2'b01, 6'b000000, 4'd4, 1'b1, 1'b1, g);
         cmp("rstMemWrite", 2'(g.memw), 2'd0);
      end

      runInstr(2'b00, 6'b101000, 4'd2, 1'b1, 4, 8'hFF);
      cmp("relIRWrite", 2'(snap[1].irw), 2'd1);
      cmp("relPCWrite", 2'(snap[1].pcw), 2'd1);
      cmp("addImmSrc", snap[1].immSrc, 2'd0);
      cmp("addSrcB3", snap[3].srcB, 2'd1);
      cmp("addAluCtl3", snap[3].aluCtl, 2'd0);
      cmp("addRegW2", 2'(snap[2].regw), 2'd0);
      cmp("addRegW3", 2'(snap[3].regw), 2'd0);
      cmp("addRegW4", 2'(snap[4].regw), 2'd1);
      cmp("addFlagW4", 2'(snap[4].flagw), 2'd0);

      runInstr(2'b00, 6'b000101, 4'd5, 1'b0, 4, 8'hFF);
      cmp("subsFetch", 2'(snap[1].irw), 2'd1);
      cmp("subsSrcB3", snap[3].srcB, 2'd0);
      cmp("subsAluCtl3", snap[3].aluCtl, 2'd1);
      cmp("subsRegW4", 2'(snap[4].regw), 2'd0);
      cmp("subsFlagW4", 2'(snap[4].flagw), 2'd0);

      runInstr(2'b01, 6'b011001, 4'd3, 1'b1, 7, 8'b0110_0111);
      cmp("ldrFetch", 2'(snap[1].irw), 2'd1);
      cmp("ldrAdr4", 2'(snap[4].adrSrc), 2'd1);
      cmp("ldrStallIrw", 2'(snap[5].irw), 2'd0);
      cmp("ldrRegW6", 2'(snap[6].regw), 2'd0);
      cmp("ldrRes7", snap[7].resSrc, 2'd1);
      cmp("ldrRegW7", 2'(snap[7].regw), 2'd1);

      runInstr(2'b10, 6'b000000, 4'd0, 1'b1, 3, 8'hFF);
      cmp("ldrLenFetch", 2'(snap[1].irw), 2'd1);
      cmp("brPCW2", 2'(snap[2].pcw), 2'd0);
      cmp("brPCW3", 2'(snap[3].pcw), 2'd1);
      cmp("brImmSrc", snap[3].immSrc, 2'd2);
      cmp("brRegSrc", snap[3].regSrc, 2'd1);

      runInstr(2'b10, 6'b000000, 4'd0, 1'b0, 3, 8'hFF);
      cmp("brNcFetchPcw", 2'(snap[1].pcw), 2'd1);
      cmp("brNcPCW3", 2'(snap[3].pcw), 2'd0);

      runInstr(2'b11, 6'b000000, 4'd1, 1'b1, 3, 8'hFF);
      cmp("undU2", 2'(snap[2].undef), 2'd0);
      cmp("undU3", 2'(snap[3].undef), 2'd1);
      cmp("undRegW3", 2'(snap[3].regw), 2'd0);
      cmp("undPCW3", 2'(snap[3].pcw), 2'd0);
      cmp("undMemW3", 2'(snap[3].memw), 2'd0);

      runInstr(2'b00, 6'b001000, 4'd15, 1'b1, 4, 8'hFF);
      cmp("undLenFetch", 2'(snap[1].irw), 2'd1);
      cmp("r15PCW4", 2'(snap[4].pcw), 2'd1);
      cmp("r15RegW4", 2'(snap[4].regw), 2'd0);

      op = 2'b00; f = 6'd0; rd = 4'd0;
      for (int i = 0; i < 3000; i++) begin
         if (mStep == 0) begin
            op = 2'($urandom_range(0, 3));
            f  = 6'($urandom);
            if ($urandom_range(0, 4) != 0) f[4:1] = cmds[$urandom_range(0, 3)];
            rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
         end
         applyStimulus(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1, op, f, rd,
                       1'($urandom), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, g);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
